// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read-channel arbiter sharing one slave port; round-robin on
// contention, one burst in flight at a time, sticky flag on beat-count mismatch.
//
// state | meaning
// IDLE  | no transaction; arbitrate pending arvalids
// ADDR  | granted master's AR forwarded to the slave, waiting for handshake
// DATA  | slave R beats routed to granted master until rlast
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  // m0: instruction cache
  input  logic              m0_arvalid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_arready,
  input  logic              m0_rready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  // m1: load/store unit
  input  logic              m1_arvalid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_arready,
  input  logic              m1_rready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  // shared slave
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  output logic              s_rready,
  // status
  output logic              grant,
  output logic              busy,
  output logic              err_len
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state, state_nxt;
  logic       grant_q, grant_nxt;
  logic       last_q, last_nxt;
  logic [7:0] len_q, len_nxt;
  logic [8:0] cnt_q, cnt_nxt;
  logic       err_q, err_nxt;

  logic       sel_arvalid;
  logic       sel_rready;
  logic       beat;
  logic [8:0] len_p1;
  logic [8:0] beat_num;

  assign grant    = grant_q;
  assign busy     = (state != IDLE);
  assign err_len  = err_q;
  assign len_p1   = {1'b0, len_q} + 9'd1;
  assign beat_num = cnt_q + 9'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
      len_q   <= len_nxt;
      cnt_q   <= cnt_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_q;
    last_nxt    = last_q;
    len_nxt     = len_q;
    cnt_nxt     = cnt_q;
    err_nxt     = err_q;

    s_arvalid   = 1'b0;
    s_araddr    = '0;
    s_arlen     = '0;
    s_arsize    = '0;
    s_arburst   = '0;
    s_rready    = 1'b0;
    m0_arready  = 1'b0;
    m1_arready  = 1'b0;
    m0_rvalid   = 1'b0;
    m0_rdata    = '0;
    m0_rresp    = '0;
    m0_rlast    = 1'b0;
    m1_rvalid   = 1'b0;
    m1_rdata    = '0;
    m1_rresp    = '0;
    m1_rlast    = 1'b0;

    sel_arvalid = grant_q ? m1_arvalid : m0_arvalid;
    sel_rready  = grant_q ? m1_rready  : m0_rready;
    beat        = 1'b0;

    case (state)
      IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          // On contention the master not served last wins
          grant_nxt = (m0_arvalid && m1_arvalid) ? ~last_q : m1_arvalid;
          state_nxt = ADDR;
        end
      end

      ADDR: begin
        s_arvalid  = sel_arvalid;
        s_araddr   = grant_q ? m1_araddr  : m0_araddr;
        s_arlen    = grant_q ? m1_arlen   : m0_arlen;
        s_arsize   = grant_q ? m1_arsize  : m0_arsize;
        s_arburst  = grant_q ? m1_arburst : m0_arburst;
        m0_arready = ~grant_q & s_arready;
        m1_arready =  grant_q & s_arready;
        if (sel_arvalid && s_arready) begin
          len_nxt   = s_arlen;
          cnt_nxt   = '0;
          state_nxt = DATA;
        end
      end

      DATA: begin
        s_rready = sel_rready;
        if (grant_q) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          m1_rlast  = s_rlast;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          m0_rlast  = s_rlast;
        end
        beat = s_rvalid & sel_rready;
        if (beat) begin
          cnt_nxt = beat_num;
          if (s_rlast) begin
            if (beat_num != len_p1) err_nxt = 1'b1;
            last_nxt  = grant_q;
            state_nxt = IDLE;
          end else if (cnt_q == len_p1) begin
            err_nxt = 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: scoreboard of expected R beats, immediate
// assertions at each comparison point.
module tb_axi_rd_arbiter;

  logic        clock, reset;
  logic        m0_arvalid, m0_arready, m0_rready, m0_rvalid, m0_rlast;
  logic [31:0] m0_araddr, m0_rdata;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst, m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rready, m1_rvalid, m1_rlast;
  logic [31:0] m1_araddr, m1_rdata;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_arburst, m1_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic        grant, busy, err_len;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          m;
    logic [31:0] data;
    bit          last;
  } exp_t;
  exp_t sb[$];

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready),
    .m0_rready(m0_rready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready),
    .m1_rready(m1_rready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rready(s_rready),
    .grant(grant), .busy(busy), .err_len(err_len)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input bit m, input logic [31:0] addr, input logic [7:0] len);
    if (m) begin
      m1_arvalid = 1'b1; m1_araddr = addr; m1_arlen = len; m1_arsize = 3'd2; m1_arburst = 2'd1;
    end else begin
      m0_arvalid = 1'b1; m0_araddr = addr; m0_arlen = len; m0_arsize = 3'd2; m0_arburst = 2'd1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},   grant, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_err"},     err_len, 0);
    check({tag, "_valids"},  {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}, 0);
    check({tag, "_rdata"},   {m0_rdata, m1_rdata}, 0);
  endtask

  // Called at #1 after an edge with the DUT in IDLE and the request already set.
  task automatic addr_phase(input bit m, input logic [31:0] addr, input logic [7:0] len,
                            input int stall, input bit drop);
    @(negedge clock);
    check("idle_busy", busy, 0);
    check("idle_s_arvalid", s_arvalid, 0);
    next_cycle();
    s_arready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      check("stall_busy", busy, 1);
      check("stall_grant", grant, m);
      check("stall_s_arvalid", s_arvalid, 1);
      check("stall_s_araddr", s_araddr, addr);
      check("stall_arready", m ? m1_arready : m0_arready, 0);
      next_cycle();
    end
    s_arready = 1'b1;
    @(negedge clock);
    check("addr_grant", grant, m);
    check("addr_s_arvalid", s_arvalid, 1);
    check("addr_s_araddr", s_araddr, addr);
    check("addr_s_arlen", s_arlen, len);
    check("addr_own_arready", m ? m1_arready : m0_arready, 1);
    check("addr_other_arready", m ? m0_arready : m1_arready, 0);
    next_cycle();
    s_arready = 1'b0;
    if (drop) begin
      if (m) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
    end
  endtask

  task automatic run_beats(input bit m, input int n, input int last_at, input logic [31:0] base);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      s_rvalid = 1'b1;
      s_rdata  = base + 32'(i);
      s_rresp  = 2'd0;
      s_rlast  = (i == last_at);
      sb.push_back('{m: m, data: base + 32'(i), last: (i == last_at)});
      @(negedge clock);
      e = sb.pop_front();
      check("beat_rvalid", e.m ? m1_rvalid : m0_rvalid, 1);
      check("beat_rdata",  e.m ? m1_rdata  : m0_rdata,  e.data);
      check("beat_rlast",  e.m ? m1_rlast  : m0_rlast,  e.last);
      check("beat_other_rvalid", e.m ? m0_rvalid : m1_rvalid, 0);
      check("beat_other_rdata",  e.m ? m0_rdata  : m1_rdata,  0);
      check("beat_s_rready", s_rready, 1);
      next_cycle();
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    m0_arvalid = 0; m0_araddr = 0; m0_arlen = 0; m0_arsize = 0; m0_arburst = 0; m0_rready = 1;
    m1_arvalid = 0; m1_araddr = 0; m1_arlen = 0; m1_arsize = 0; m1_arburst = 0; m1_rready = 1;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    next_cycle();
    reset = 1'b1;

    // m0 only, 4-beat burst
    set_req(0, 32'h8000_0000, 8'd3);
    addr_phase(0, 32'h8000_0000, 8'd3, 0, 1);
    run_beats(0, 4, 3, 32'h11);
    @(negedge clock);
    check("t1_busy_after_rlast", busy, 0);
    check("t1_err", err_len, 0);
    check("t1_grant_held", grant, 0);
    // stray slave beat in IDLE is ignored
    s_rvalid = 1'b1; s_rdata = 32'hdead; s_rlast = 1'b0;
    @(negedge clock);
    check("idle_stray_m0_rvalid", m0_rvalid, 0);
    check("idle_stray_s_rready", s_rready, 0);
    next_cycle();
    s_rvalid = 1'b0;
    @(negedge clock);
    check("idle_stray_err", err_len, 0);
    next_cycle();

    // simultaneous requests after reset: m0 first, then m1
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    set_req(0, 32'h0000_1000, 8'd1);
    set_req(1, 32'h0000_2000, 8'd1);
    addr_phase(0, 32'h0000_1000, 8'd1, 0, 1);
    run_beats(0, 2, 1, 32'h100);
    addr_phase(1, 32'h0000_2000, 8'd1, 0, 1);
    run_beats(1, 2, 1, 32'h200);

    // m0 keeps requesting while m1 pending: m0, m1, m0
    set_req(0, 32'h0000_3000, 8'd0);
    set_req(1, 32'h0000_4000, 8'd0);
    addr_phase(0, 32'h0000_3000, 8'd0, 0, 0);
    run_beats(0, 1, 0, 32'h300);
    addr_phase(1, 32'h0000_4000, 8'd0, 0, 1);
    run_beats(1, 1, 0, 32'h400);
    addr_phase(0, 32'h0000_3000, 8'd0, 0, 1);
    run_beats(0, 1, 0, 32'h500);

    // m1 single read with slave stalling AR for 5 cycles
    set_req(1, 32'h0000_5000, 8'd0);
    addr_phase(1, 32'h0000_5000, 8'd0, 5, 1);
    run_beats(1, 1, 0, 32'h600);

    // early rlast: err_len sets and stays set
    set_req(0, 32'h0000_6000, 8'd3);
    addr_phase(0, 32'h0000_6000, 8'd3, 0, 1);
    @(negedge clock);
    check("t5_err_before", err_len, 0);
    next_cycle();
    run_beats(0, 2, 1, 32'h700);
    @(negedge clock);
    check("t5_err_set", err_len, 1);
    check("t5_busy", busy, 0);
    next_cycle();
    set_req(1, 32'h0000_7000, 8'd1);
    addr_phase(1, 32'h0000_7000, 8'd1, 0, 1);
    run_beats(1, 2, 1, 32'h800);
    @(negedge clock);
    check("t5_err_sticky", err_len, 1);
    next_cycle();

    // reset during beat 2 of a 4-beat burst
    set_req(0, 32'h0000_8000, 8'd3);
    addr_phase(0, 32'h0000_8000, 8'd3, 0, 1);
    run_beats(0, 1, -1, 32'h900);
    s_rvalid = 1'b1; s_rdata = 32'h901; s_rlast = 1'b0;
    #2 reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("midreset");
    next_cycle();
    reset = 1'b1;
    s_rvalid = 1'b0;
    set_req(1, 32'h0000_9000, 8'd1);
    addr_phase(1, 32'h0000_9000, 8'd1, 0, 1);
    run_beats(1, 2, 1, 32'hA00);
    @(negedge clock);
    check("t6_busy_end", busy, 0);
    check("t6_err_end", err_len, 0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
